// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the MCP3008-style ADC scan sequencer.
//   - adc_state_e    : sequencer FSM states
//   - ADC_* widths   : SPI frame, result and channel sizes
//   - adc_cmd_frame(): builds the 24-bit single-ended conversion command
package adc_pkg;

  localparam int ADC_FRAME_BITS   = 24;
  localparam int ADC_RESULT_BITS  = 10;
  localparam int ADC_NUM_CHANNELS = 8;
  localparam int ADC_CHAN_BITS    = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    CAPTURE
  } adc_state_e;

  // Start byte 0x01, then SGL=1, channel D2..D0, four don't-care bits,
  // and a trailing byte that clocks out the remaining result bits.
  function automatic logic [ADC_FRAME_BITS-1:0] adc_cmd_frame(
    input logic [ADC_CHAN_BITS-1:0] ch
  );
    return {8'h01, 1'b1, ch, 4'h0, 8'h00};
  endfunction

endpackage

// File: rtl/round_robin_select.sv
// round_robin_select: picks the next enabled ADC channel.
//   mask_i     [7:0] channel enable mask (bit i = channel i)
//   last_i     [2:0] last channel converted
//   next_idx_o [2:0] lowest set bit strictly above last_i, else lowest set bit
// Purely combinational. With an all-zero mask the output is 0; callers
// must not start a conversion in that case.
module round_robin_select
  import adc_pkg::*;
(
  input  logic [ADC_NUM_CHANNELS-1:0] mask_i,
  input  logic [ADC_CHAN_BITS-1:0]    last_i,
  output logic [ADC_CHAN_BITS-1:0]    next_idx_o
);

  logic [ADC_CHAN_BITS-1:0] lowest;
  logic [ADC_CHAN_BITS-1:0] above;
  logic                     have_above;

  // Scan downwards so the last hit in each category is the lowest index.
  always_comb begin
    lowest     = '0;
    above      = '0;
    have_above = 1'b0;
    for (int i = ADC_NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        lowest = ADC_CHAN_BITS'(i);
        if (ADC_CHAN_BITS'(i) > last_i) begin
          above      = ADC_CHAN_BITS'(i);
          have_above = 1'b1;
        end
      end
    end
    next_idx_o = have_above ? above : lowest;
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: periodic round-robin scanner for an 8-channel 10-bit
// SPI ADC, driving a 24-bit SPI controller.
//   clk, rst_n          clock, synchronous active-low reset
//   chan_mask, enable   channel enable mask, scan enable
//   spi_axiiv/axiid     one-cycle frame-valid pulse and held command frame
//   spi_axiready/axiod  controller idle flag and received frame
//   sample_valid/data/chan  tagged conversion result (one-cycle pulse)
//   overrun, timeout    one-cycle event pulses
//   dbg_state           current FSM state (adc_state_e encoding)
//
// Handshake with the SPI controller: a frame is offered only while
// spi_axiready is high, as a single-cycle spi_axiiv pulse with spi_axiid
// stable. The controller takes it by dropping spi_axiready, and signals
// completion by raising spi_axiready again; spi_axiod is captured only in
// that completion cycle.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int SAMPLE_PERIOD  = 100000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADC_NUM_CHANNELS-1:0] chan_mask,
  input  logic                       enable,
  output logic                       spi_axiiv,
  output logic [ADC_FRAME_BITS-1:0]  spi_axiid,
  input  logic                       spi_axiready,
  input  logic [ADC_FRAME_BITS-1:0]  spi_axiod,
  output logic                       sample_valid,
  output logic [ADC_RESULT_BITS-1:0] sample_data,
  output logic [ADC_CHAN_BITS-1:0]   sample_chan,
  output logic                       overrun,
  output logic                       timeout,
  output logic [2:0]                 dbg_state
);

  localparam int TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  adc_state_e                 state_q, state_d;
  logic [TICK_W-1:0]          tick_cnt_q, tick_cnt_d;
  logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
  // Last selected channel; also the channel of the frame in flight.
  logic [ADC_CHAN_BITS-1:0]   ch_q, ch_d;
  logic                       spi_axiiv_q, spi_axiiv_d;
  logic [ADC_FRAME_BITS-1:0]  spi_axiid_q, spi_axiid_d;
  logic [ADC_RESULT_BITS-1:0] sample_data_q, sample_data_d;
  logic [ADC_CHAN_BITS-1:0]   sample_chan_q, sample_chan_d;
  logic                       overrun_q, overrun_d;
  logic                       timeout_q, timeout_d;

  logic [ADC_CHAN_BITS-1:0]   rr_next;
  logic                       tick;
  logic                       in_flight;
  logic                       expired;
  logic                       start;
  logic                       unused_od_hi;

  assign tick       = (tick_cnt_q == TICK_W'(SAMPLE_PERIOD - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  assign in_flight  = (state_q == ISSUE) || (state_q == WAIT_LOW) ||
                      (state_q == WAIT_HIGH);
  // Expiry overrides any handshake progress made in the same cycle.
  assign expired    = in_flight && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign start      = (state_q == IDLE) && tick && enable && (chan_mask != '0);

  // Only the low result bits of the returned frame carry data.
  assign unused_od_hi = ^spi_axiod[ADC_FRAME_BITS-1:ADC_RESULT_BITS];

  round_robin_select u_rr (
    .mask_i     (chan_mask),
    .last_i     (ch_q),
    .next_idx_o (rr_next)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      to_cnt_q      <= '0;
      ch_q          <= ADC_CHAN_BITS'(ADC_NUM_CHANNELS - 1);
      spi_axiiv_q   <= 1'b0;
      spi_axiid_q   <= '0;
      sample_data_q <= '0;
      sample_chan_q <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      to_cnt_q      <= to_cnt_d;
      ch_q          <= ch_d;
      spi_axiiv_q   <= spi_axiiv_d;
      spi_axiid_q   <= spi_axiid_d;
      sample_data_q <= sample_data_d;
      sample_chan_q <= sample_chan_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = ISSUE;
      ISSUE:     if (expired) state_d = IDLE;
                 else if (spi_axiready) state_d = WAIT_LOW;
      WAIT_LOW:  if (expired) state_d = IDLE;
                 else if (!spi_axiready) state_d = WAIT_HIGH;
      WAIT_HIGH: if (expired) state_d = IDLE;
                 else if (spi_axiready) state_d = CAPTURE;
      CAPTURE:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    ch_d          = ch_q;
    to_cnt_d      = to_cnt_q;
    spi_axiiv_d   = 1'b0;
    spi_axiid_d   = spi_axiid_q;
    sample_data_d = sample_data_q;
    sample_chan_d = sample_chan_q;
    // A tick is dropped (and flagged) whenever the sequencer is not idle.
    overrun_d     = tick && enable && (state_q != IDLE);
    timeout_d     = expired;

    if (start) begin
      // The pointer advances at selection, so a timed-out channel is skipped next time.
      ch_d     = rr_next;
      to_cnt_d = '0;
    end else if (in_flight) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if ((state_q == ISSUE) && !expired && spi_axiready) begin
      spi_axiiv_d = 1'b1;
      spi_axiid_d = adc_cmd_frame(ch_q);
    end

    if ((state_q == WAIT_HIGH) && !expired && spi_axiready) begin
      sample_data_d = spi_axiod[ADC_RESULT_BITS-1:0];
      sample_chan_d = ch_q;
    end
  end

  assign sample_valid = (state_q == CAPTURE);
  assign spi_axiiv    = spi_axiiv_q;
  assign spi_axiid    = spi_axiid_q;
  assign sample_data  = sample_data_q;
  assign sample_chan  = sample_chan_q;
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: randomized bench for adc_scan_sequencer with a
// reactive SPI-controller model and a timestamp-based reference model.
module tb_adc_scan_sequencer;

  localparam int P    = 20;
  localparam int TO   = 50;
  localparam int HANG = 30000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  chan_mask = 8'h00;
  logic        spi_axiready = 1'b1;
  logic [23:0] spi_axiod = 24'h0;
  logic        spi_axiiv;
  logic [23:0] spi_axiid;
  logic        sample_valid;
  logic [9:0]  sample_data;
  logic [2:0]  sample_chan;
  logic        overrun;
  logic        timeout;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  adc_scan_sequencer #(.SAMPLE_PERIOD(P), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .chan_mask    (chan_mask),
    .enable       (enable),
    .spi_axiiv    (spi_axiiv),
    .spi_axiid    (spi_axiid),
    .spi_axiready (spi_axiready),
    .spi_axiod    (spi_axiod),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_chan  (sample_chan),
    .overrun      (overrun),
    .timeout      (timeout),
    .dbg_state    (dbg_state)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Values applied to the DUT at the start of the next cycle.
  logic       drv_rst_n = 1'b0;
  logic       drv_en    = 1'b0;
  logic [7:0] drv_mask  = 8'h00;
  bit         od_fixed  = 1'b1;

  // SPI controller model: busy for resp_b cycles after each frame.
  int resp_busy = 0;
  int resp_b    = 3;
  int force_low = 0;

  // Reference model: tick phase, conversion milestones, next-cycle expectations.
  int         j = 0;
  bit         m_busy = 0, m_issued = 0, m_accepted = 0, m_done = 0;
  int         m_t0 = 0;
  logic [2:0] m_last = 3'd7;
  logic [2:0] m_ch = 3'd0;
  bit         e_iv = 0, e_sv = 0, e_ov = 0, e_to = 0, e_zero = 1;
  logic [23:0] e_id = 24'h0;
  logic [12:0] exp_q[$];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  // Circular search upward from the last channel.
  function automatic logic [2:0] model_next(input logic [7:0] mask, input logic [2:0] last);
    int c;
    for (int k = 1; k <= 8; k++) begin
      c = (int'(last) + k) % 8;
      if (mask[c]) return 3'(c);
    end
    return last;
  endfunction

  function automatic logic [23:0] model_frame(input logic [2:0] ch);
    return 24'h018000 | (24'(ch) << 12);
  endfunction

  // Compare this cycle's outputs, then decide what the next cycle must show.
  task automatic model_cycle();
    bit tick, was_busy;
    bit n_iv, n_sv, n_ov, n_to;
    logic [12:0] want;

    check("iv", spi_axiiv, e_iv);
    check("sample_valid", sample_valid, e_sv);
    check("overrun", overrun, e_ov);
    check("timeout", timeout, e_to);
    check("axiid", spi_axiid, e_id);
    if (e_zero) begin
      check("data_rst", sample_data, 0);
      check("chan_rst", sample_chan, 0);
      check("state_rst", dbg_state, 0);
    end
    if (sample_valid && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check("sample", {sample_chan, sample_data}, want);
    end

    n_iv = 0; n_sv = 0; n_ov = 0; n_to = 0;
    if (!rst_n) begin
      m_busy = 0; m_last = 3'd7; j = 0; e_id = 24'h0; e_zero = 1;
      exp_q.delete();
    end else begin
      e_zero   = 0;
      tick     = (j == P - 1);
      was_busy = m_busy;
      if (was_busy) begin
        if (tick && enable) n_ov = 1;
        if (m_done) begin
          m_busy = 0;                         // sample cycle ends the conversion
        end else if (cyc == m_t0 + TO) begin
          n_to = 1; m_busy = 0;               // expiry beats any handshake progress
        end else if (!m_issued) begin
          if (spi_axiready) begin
            m_issued = 1; n_iv = 1; e_id = model_frame(m_ch);
          end
        end else if (!m_accepted) begin
          if (!spi_axiready) m_accepted = 1;
        end else if (spi_axiready) begin
          m_done = 1; n_sv = 1;
          exp_q.push_back({m_ch, spi_axiod[9:0]});
        end
      end else if (tick && enable && chan_mask != 8'h00) begin
        m_ch = model_next(chan_mask, m_last);
        m_last = m_ch;
        m_busy = 1; m_t0 = cyc;
        m_issued = 0; m_accepted = 0; m_done = 0;
      end
      j = (j == P - 1) ? 0 : j + 1;
    end
    e_iv = n_iv; e_sv = n_sv; e_ov = n_ov; e_to = n_to;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    rst_n        = drv_rst_n;
    enable       = drv_en;
    chan_mask    = drv_mask;
    spi_axiready = (resp_busy == 0) && (force_low == 0);
    if (resp_busy > 0) resp_busy--;
    if (force_low > 0) force_low--;
    spi_axiod    = od_fixed ? 24'h0003FF : 24'($urandom);
    #4;
    model_cycle();
    if (!rst_n) resp_busy = 0;
    else if (spi_axiiv) resp_busy = resp_b;
    cyc++;
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- stimulus ----------------
  int b_table[5] = '{3, 16, 30, 46, 47};
  bit reached;

  initial begin
    // Reset and basic scan over channels 0 and 2 with a fixed result.
    step_n(3);
    drv_rst_n = 1; drv_en = 1; drv_mask = 8'h05; resp_b = 3;
    step_n(90);

    // Single high channel, then a mask change between ticks.
    od_fixed = 0;
    drv_mask = 8'h80;
    step_n(70);
    drv_mask = 8'h01;
    step_n(50);

    // Ready arrives late: held low across a tick.
    for (int k = 0; k < P + 2 && j != P - 4; k++) step();
    force_low = 15;
    step_n(40);

    // Busy lengths: capture on a tick, overruns, done just before and at expiry.
    drv_mask = 8'h5A;
    foreach (b_table[i]) begin
      resp_b = b_table[i];
      step_n(130);
    end

    // Controller never finishes: timeout, then recovery on the next tick.
    resp_b = HANG;
    step_n(70);
    resp_busy = 0; resp_b = 3;
    step_n(60);

    // Random enable / mask / busy-length traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 29) == 0) drv_en = ~drv_en;
      if ($urandom_range(0, 59) == 0)
        drv_mask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) resp_b = $urandom_range(1, 25);
      step();
    end

    // Reset while waiting for the frame to complete.
    drv_en = 1; drv_mask = 8'h0C; resp_b = 20;
    reached = 0;
    for (int k = 0; k < 200 && !reached; k++) begin
      step();
      if (m_busy && m_accepted && !m_done) reached = 1;
    end
    check("wait_high_reached", reached, 1);
    drv_rst_n = 0;
    step();
    drv_rst_n = 1; drv_mask = 8'h36; resp_b = 4;
    step_n(100);

    // Drain.
    drv_en = 0;
    step_n(80);
    check("sample_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
